// File: rtl/stage_ex_pipe.sv
// stage_ex_pipe: registered execute stage of the mini processor.
// ALU operation, signed compare / branch resolution and the EX/MEM register,
// with a valid/ready handshake on both sides and a synchronous flush.
// A taken branch drives a one-cycle pc_write pulse and the target PC.
//
// Optional feature, enabled by defining STAGE_EX_MUL_EN:
//   aluctrl=10 runs an iterative shift-add multiply (1 multiplier bit per
//   cycle). Without the macro, aluctrl=10 yields 0 with single-cycle latency.
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready          upstream handshake
//   r1_data, r2_data, st_data  operands and store data
//   wReg1_in, aluctrl, WRegEn_in, WMemEn_in, br_en, br_cond, br_target
//   flush                      synchronous kill of in-flight work
//   out_valid/out_ready        downstream handshake
//   wReg1_out, mem_addr, wdata, WRegEn_out, WMemEn_out   EX/MEM register
//   pc_write, pc               branch-taken pulse and target
//
// state  | meaning
// S_IDLE | accepting beats (when the EX/MEM register can drain)
// S_MUL  | shift-add multiply in progress
// S_DONE | product ready, waiting to enter the EX/MEM register
module stage_ex_pipe #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR        = 3,
  parameter int IMEM_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      r1_data,
  input  logic [DATA_WIDTH-1:0]      r2_data,
  input  logic [DATA_WIDTH-1:0]      st_data,
  input  logic [REG_ADDR-1:0]        wReg1_in,
  input  logic [3:0]                 aluctrl,
  input  logic                       WRegEn_in,
  input  logic                       WMemEn_in,
  input  logic                       br_en,
  input  logic [2:0]                 br_cond,
  input  logic [IMEM_ADDR_WIDTH-1:0] br_target,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REG_ADDR-1:0]        wReg1_out,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       WRegEn_out,
  output logic                       WMemEn_out,
  output logic                       pc_write,
  output logic [IMEM_ADDR_WIDTH-1:0] pc
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic [REG_ADDR-1:0]        wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]      res_q, res_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       we_q, we_d;
  logic                       wme_q, wme_d;
  logic                       pc_write_q, pc_write_d;
  logic [IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;

`ifdef STAGE_EX_MUL_EN
  localparam int CW = $clog2(DATA_WIDTH + 1);
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
`endif

  logic [DATA_WIDTH-1:0] diff;
  logic                  ovf, eq, lt, gt, taken, accept;
  logic [DATA_WIDTH-1:0] alu_res;

  // Signed compare from the subtraction: overflow flips the sign bit's meaning.
  assign diff = r1_data - r2_data;
  assign ovf  = (r1_data[MSB] ^ r2_data[MSB]) & (diff[MSB] ^ r1_data[MSB]);
  assign eq   = (diff == '0);
  assign lt   = diff[MSB] ^ ovf;
  assign gt   = !lt && !eq;

  always_comb begin
    taken = 1'b0;
    case (br_cond)
      3'd0: taken = eq;
      3'd1: taken = !eq;
      3'd2: taken = lt;
      3'd3: taken = !lt;
      3'd4: taken = gt;
      3'd5: taken = !gt;
      3'd6: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (aluctrl)
      4'd0: alu_res = r1_data + r2_data;
      4'd1: alu_res = diff;
      4'd2: alu_res = r1_data & r2_data;
      4'd3: alu_res = r1_data | r2_data;
      4'd4: alu_res = r1_data ^ r2_data;
      4'd5: alu_res = ~(r1_data | r2_data);
      4'd6: alu_res = r1_data << r2_data[4:0];
      4'd7: alu_res = r1_data >> r2_data[4:0];
      4'd8: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt};
      4'd9: alu_res = r2_data;
      default: alu_res = '0;
    endcase
  end

  assign in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  // Flush kills a same-cycle beat, so it is folded into acceptance.
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    wreg_d      = wreg_q;
    res_d       = res_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wme_d       = wme_q;
    pc_write_d  = 1'b0;
    pc_d        = pc_q;
`ifdef STAGE_EX_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif

    if (accept) begin
      // The EX/MEM register is free on any acceptance, so a multiply parks
      // its side-band fields there (invalid) until the product arrives.
      wreg_d  = wReg1_in;
      res_d   = alu_res;
      wdata_d = st_data;
      we_d    = WRegEn_in;
      wme_d   = WMemEn_in;
`ifdef STAGE_EX_MUL_EN
      if (aluctrl == 4'd10) begin
        out_valid_d = 1'b0;
        state_d     = S_MUL;
        mcand_d     = r1_data;
        mplier_d    = r2_data;
        acc_d       = '0;
        cnt_d       = CW'(DATA_WIDTH);
      end else
`endif
      begin
        out_valid_d = 1'b1;
        if (br_en && taken) begin
          pc_write_d = 1'b1;
          pc_d       = br_target;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

`ifdef STAGE_EX_MUL_EN
    case (state_q)
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q || out_ready) begin
          res_d       = acc_q;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase
`endif

    if (flush) begin
      out_valid_d = 1'b0;
      pc_write_d  = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      wreg_q      <= '0;
      res_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wme_q       <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_q        <= '0;
`ifdef STAGE_EX_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      wreg_q      <= wreg_d;
      res_q       <= res_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wme_q       <= wme_d;
      pc_write_q  <= pc_write_d;
      pc_q        <= pc_d;
`ifdef STAGE_EX_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign wReg1_out  = wreg_q;
  assign mem_addr   = res_q;
  assign wdata      = wdata_q;
  assign WRegEn_out = we_q & out_valid_q;
  assign WMemEn_out = wme_q & out_valid_q;
  assign pc_write   = pc_write_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_stage_ex_pipe.sv
// Testbench for stage_ex_pipe: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_stage_ex_pipe;

  localparam int DW = 32;
  localparam int RA = 3;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] r1_data, r2_data, st_data;
  logic [RA-1:0] wReg1_in;
  logic [3:0]    aluctrl;
  logic          WRegEn_in, WMemEn_in, br_en;
  logic [2:0]    br_cond;
  logic [IW-1:0] br_target;
  logic          flush;
  logic          out_valid, out_ready;
  logic [RA-1:0] wReg1_out;
  logic [DW-1:0] mem_addr, wdata;
  logic          WRegEn_out, WMemEn_out, pc_write;
  logic [IW-1:0] pc;

  stage_ex_pipe #(.DATA_WIDTH(DW), .REG_ADDR(RA), .IMEM_ADDR_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .r1_data(r1_data), .r2_data(r2_data), .st_data(st_data),
    .wReg1_in(wReg1_in), .aluctrl(aluctrl), .WRegEn_in(WRegEn_in),
    .WMemEn_in(WMemEn_in), .br_en(br_en), .br_cond(br_cond),
    .br_target(br_target), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .wReg1_out(wReg1_out), .mem_addr(mem_addr),
    .wdata(wdata), .WRegEn_out(WRegEn_out), .WMemEn_out(WMemEn_out),
    .pc_write(pc_write), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: what the memory stage should currently see.
  logic          m_ov, m_we, m_wme, m_pcw;
  logic [DW-1:0] m_res, m_wdata;
  logic [RA-1:0] m_wreg;
  logic [IW-1:0] m_pc;
  int            m_busy;
  logic [DW-1:0] p_a, p_b, p_wdata;
  logic [RA-1:0] p_wreg;
  logic          p_we, p_wme;

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      4'd9: return b;
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] c, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) <  $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return $signed(a) >  $signed(b);
      3'd5: return $signed(a) <= $signed(b);
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_in_ready();
    return !reset && (m_busy == 0) && (!m_ov || out_ready);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef STAGE_EX_MUL_EN
    return op == 4'd10;
`else
    return op == 4'd15 && op == 4'd10;
`endif
  endfunction

  task automatic model_reset();
    m_ov = 0; m_we = 0; m_wme = 0; m_pcw = 0; m_res = '0; m_wdata = '0;
    m_wreg = '0; m_pc = '0; m_busy = 0;
    p_a = '0; p_b = '0; p_wdata = '0; p_wreg = '0; p_we = 0; p_wme = 0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    logic          acc;
    logic [2*DW-1:0] prod;
    acc   = in_valid && m_in_ready() && !flush;
    m_pcw = 1'b0;
    if (flush) begin
      m_ov   = 1'b0;
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        prod    = {{DW{1'b0}}, p_a} * {{DW{1'b0}}, p_b};
        m_ov    = 1'b1;
        m_res   = prod[DW-1:0];
        m_wreg  = p_wreg; m_wdata = p_wdata; m_we = p_we; m_wme = p_wme;
      end
    end else if (acc) begin
      if (is_mul_op(aluctrl)) begin
        m_ov   = 1'b0;
        m_busy = DW + 1;
        p_a = r1_data; p_b = r2_data; p_wreg = wReg1_in; p_wdata = st_data;
        p_we = WRegEn_in; p_wme = WMemEn_in;
      end else begin
        m_ov    = 1'b1;
        m_res   = ref_alu(aluctrl, r1_data, r2_data);
        m_wreg  = wReg1_in; m_wdata = st_data; m_we = WRegEn_in; m_wme = WMemEn_in;
        if (br_en && ref_taken(br_cond, r1_data, r2_data)) begin
          m_pcw = 1'b1;
          m_pc  = br_target;
        end
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_ov);
    chk("WRegEn_out", WRegEn_out, m_ov ? m_we : 1'b0);
    chk("WMemEn_out", WMemEn_out, m_ov ? m_wme : 1'b0);
    chk("pc_write", pc_write, m_pcw);
    if (m_pcw) chk("pc", pc, m_pc);
    if (m_ov) begin
      chk("mem_addr", mem_addr, m_res);
      chk("wReg1_out", wReg1_out, m_wreg);
      chk("wdata", wdata, m_wdata);
    end
  endtask

  // Inputs are set at the falling edge; this checks in_ready, steps the model,
  // crosses the rising edge and checks the registered outputs.
  task automatic tick();
    #1;
    chk("in_ready", in_ready, m_in_ready());
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_wdata"}, wdata, '0);
    chk({tag, "_wReg1_out"}, wReg1_out, '0);
    chk({tag, "_WRegEn_out"}, WRegEn_out, 1'b0);
    chk({tag, "_WMemEn_out"}, WMemEn_out, 1'b0);
    chk({tag, "_pc_write"}, pc_write, 1'b0);
    chk({tag, "_pc"}, pc, '0);
  endtask

  task automatic beat(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RA-1:0] wr, input logic we, input logic be,
                      input logic [2:0] bc, input logic [IW-1:0] bt);
    in_valid = 1'b1; aluctrl = op; r1_data = a; r2_data = b; wReg1_in = wr;
    WRegEn_in = we; WMemEn_in = 1'b0; st_data = a ^ 32'h5a5a_0f0f;
    br_en = be; br_cond = bc; br_target = bt;
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'h7fff_ffff;
      3: return 32'hffff_ffff;
      4: return DW'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_inputs();
    logic [3:0] op;
    in_valid  = ($urandom_range(0, 9) < 7);
    out_ready = ($urandom_range(0, 9) < 7);
    flush     = ($urandom_range(0, 19) == 0);
    op        = 4'($urandom_range(0, 15));
`ifdef STAGE_EX_MUL_EN
    if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd0;
`endif
    aluctrl   = op;
    r1_data   = rand_word();
    r2_data   = ($urandom_range(0, 4) == 0) ? r1_data : rand_word();
    st_data   = $urandom();
    wReg1_in  = RA'($urandom());
    WRegEn_in = 1'($urandom());
    WMemEn_in = 1'($urandom());
    br_en     = 1'($urandom());
    br_cond   = 3'($urandom());
    br_target = IW'($urandom());
  endtask

  initial begin
    int lat;
    reset = 1'b1; in_valid = 0; out_ready = 1; flush = 0;
    r1_data = '0; r2_data = '0; st_data = '0; wReg1_in = '0; aluctrl = '0;
    WRegEn_in = 0; WMemEn_in = 0; br_en = 0; br_cond = '0; br_target = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // ADD 5+7 into r3
    beat(4'd0, 32'd5, 32'd7, 3'd3, 1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    chk("t1_mem_addr", mem_addr, 32'd12);
    chk("t1_wreg", wReg1_out, 3'd3);

    // SUB with overflow: 0x80000000 < 1 signed, LT branch taken
    beat(4'd1, 32'h8000_0000, 32'd1, 3'd1, 1'b0, 1'b1, 3'd2, 8'h40);
    tick();
    chk("t2_pc_write", pc_write, 1'b1);
    chk("t2_pc", pc, 8'h40);
    in_valid = 1'b0;
    tick();

    // Stall for three cycles with a new beat waiting, then release
    beat(4'd4, 32'hf0f0_1234, 32'h0ff0_4321, 3'd5, 1'b1, 1'b1, 3'd6, 8'h21);
    tick();
    out_ready = 1'b0;
    beat(4'd2, 32'hdead_beef, 32'hffff_0000, 3'd6, 1'b1, 1'b0, 3'd0, 8'h00);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();

    // Flush against a taken branch beat
    beat(4'd0, 32'd1, 32'd2, 3'd2, 1'b1, 1'b1, 3'd6, 8'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

`ifdef STAGE_EX_MUL_EN
    beat(4'd10, 32'd6, 32'd7, 3'd4, 1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("mul_latency", lat, DW + 1);
    chk("mul_result", mem_addr, 32'd42);
    tick();
    beat(4'd10, 32'd9, 32'd9, 3'd1, 1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (DW + 4) tick();
`endif

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    // Reset in the middle of a held branch beat
    out_ready = 1'b1; flush = 1'b0;
    beat(4'd3, 32'h1234_0000, 32'h0000_5678, 3'd7, 1'b1, 1'b1, 3'd6, 8'h99);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    beat(4'd0, 32'd100, 32'd23, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    chk("post_rst_sum", mem_addr, 32'd123);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
